cell_address_allocator: RTL

- Sits directly downstream of the serial-to-parallel converter top. It owns the pool of free cell-buffer addresses.
- Each cycle it presents the next free address and a reject flag to the converter. It consumes the converter's write strobe and info.
- It emits a registered cell descriptor (address, port, info) to the output-queue manager.
- Addresses come back via a release interface once a cell has been read out of the buffer.

---
 rtl/cell_address_allocator.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/cell_address_allocator.sv
// Cell address allocator: FIFO free list of shared-buffer cell slots with init sweep and release path.
// Optional CELL_ALLOC_DOUBLE_FREE_CHECK_EN adds an in-use bitmap and a sticky doubleFreeError output.
module cell_address_allocator #(
    parameter int  nbrOfPorts      = 1,
    parameter int  bufferAddresses = 32,
    parameter int  addressWidth    = $clog2(bufferAddresses),
    parameter type info_type       = logic [7:0],
    localparam int portWidth       = (nbrOfPorts > 1) ? $clog2(nbrOfPorts) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    writeEnable,
    input  logic [portWidth-1:0]    writePort,
    input  info_type                writeInfo,
    output logic [addressWidth-1:0] writeAddress,
    output logic                    writeRejected,
    input  logic                    releaseValid,
    input  logic [addressWidth-1:0] releaseAddress,
    output logic                    cellValid,
    output logic [addressWidth-1:0] cellAddress,
    output logic [portWidth-1:0]    cellPort,
    output info_type                cellInfo,
    output logic [addressWidth:0]   freeCount,
`ifdef CELL_ALLOC_DOUBLE_FREE_CHECK_EN
    output logic                    doubleFreeError,
`endif
    output logic                    initDone
);

    localparam logic [addressWidth:0]   fullCount = (addressWidth + 1)'(bufferAddresses);
    localparam logic [addressWidth-1:0] lastAddr  = addressWidth'(bufferAddresses - 1);

    typedef enum logic {INIT, READY} state_t;

    state_t                  state, nextState;
    logic [addressWidth-1:0] store [bufferAddresses];
    logic [addressWidth-1:0] initCnt;
    logic [addressWidth-1:0] rdPtr;
    logic [addressWidth-1:0] wrPtr;
    logic [addressWidth:0]   count;
    logic                    allocAccept;
    logic                    releaseCandidate;
    logic                    releaseAccept;

    assign writeAddress     = store[rdPtr];
    assign writeRejected    = (state == INIT) || (count == '0);
    assign allocAccept      = writeEnable && !writeRejected;
    assign releaseCandidate = releaseValid && (state == READY);
    assign freeCount        = count;
    assign initDone         = (state == READY);

`ifdef CELL_ALLOC_DOUBLE_FREE_CHECK_EN
    logic [bufferAddresses-1:0] inUse;
    logic                       doubleFree;

    // Checked against the pre-edge bitmap, so a same-cycle allocate of the same address does not legitimise it.
    assign doubleFree    = releaseCandidate && !inUse[releaseAddress];
    assign releaseAccept = releaseCandidate && (count != fullCount) && inUse[releaseAddress];

    always_ff @(posedge clk) begin
        if (rst) begin
            inUse           <= '0;
            doubleFreeError <= 1'b0;
        end else begin
            if (allocAccept) begin
                inUse[writeAddress] <= 1'b1;
            end
            if (releaseAccept) begin
                inUse[releaseAddress] <= 1'b0;
            end
            if (doubleFree) begin
                doubleFreeError <= 1'b1;
            end
        end
    end
`else
    assign releaseAccept = releaseCandidate && (count != fullCount);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        unique case (state)
            INIT:    if (initCnt == lastAddr) nextState = READY;
            READY:   nextState = READY;
            default: nextState = INIT;
        endcase
    end

    // Single write port: the init sweep and releases never overlap because releases need READY.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == INIT) begin
                store[initCnt] <= initCnt;
            end else if (releaseAccept) begin
                store[wrPtr] <= releaseAddress;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            initCnt <= '0;
            rdPtr   <= '0;
            wrPtr   <= '0;
            count   <= '0;
        end else if (state == INIT) begin
            initCnt <= initCnt + 1'b1;
            if (initCnt == lastAddr) begin
                rdPtr <= '0;
                wrPtr <= '0;
                count <= fullCount;
            end
        end else begin
            if (allocAccept) begin
                rdPtr <= rdPtr + 1'b1;
            end
            if (releaseAccept) begin
                wrPtr <= wrPtr + 1'b1;
            end
            unique case ({releaseAccept, allocAccept})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cellValid   <= 1'b0;
            cellAddress <= '0;
            cellPort    <= '0;
            cellInfo    <= '0;
        end else begin
            cellValid <= allocAccept;
            if (allocAccept) begin
                cellAddress <= writeAddress;
                cellPort    <= writePort;
                cellInfo    <= writeInfo;
            end
        end
    end

endmodule
